keypad_pin_entry: RTL
=====================

// Module: keypad_pin_entry
// PURPOSE
//  Collects digit keystrokes from the gate keypad, assembles a DIGITS-long BCD PIN and presents it to the
//  parking gate controller's password input via a valid/ready handshake. Sits between the keypad scanner and
//  the gate controller; lock_in is driven by the controller's blocked alarm and freezes entry while high.
// PARAMETERS
//  DIGITS       4     number of BCD digits per PIN; pin_data width = 4*DIGITS
//  TIMEOUT_CYC  1000  idle clk cycles in COLLECT before the partial entry is discarded (>=2)
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         reset, asynchronous, active-high
//  key_valid    in   1         one-cycle strobe, key_code is valid
//  key_code     in   4         0-9 digit, 4'hA clear, 4'hB backspace, 4'hE enter, others invalid
//  lock_in      in   1         entry lockout (gate controller blocked alarm)
//  pin_ready    in   1         consumer accepts pin_data this cycle
//  pin_valid    out  1         pin_data holds a complete PIN
//  pin_data     out  4*DIGITS  assembled PIN, first digit in MS nibble (keys 1,2,3,4 -> 16'h1234)
//  entry_active out  1         high in COLLECT
//  digit_count  out  3         digits currently held (0..DIGITS)
//  entry_error  out  1         one-cycle pulse on a rejected key or timeout
// BEHAVIOUR
//  - Reset: state IDLE; pin_valid=0, pin_data=0, entry_active=0, digit_count=0, entry_error=0, timer=0.
//    Reset asserted mid-entry or mid-handshake discards everything immediately.
//  - All outputs registered; every effect appears the cycle after the sampling edge.
//  - States: IDLE, COLLECT, SEND, LOCKED. lock_in has top priority: from any state, lock_in=1 -> LOCKED
//    next cycle; buffer cleared, digit_count=0, pin_valid=0, a same-cycle key is ignored.
//  - IDLE: digit key -> buffer={0..,digit}, digit_count=1, COLLECT. Enter/backspace/clear ignored silently;
//    invalid code -> entry_error pulse.
//  - COLLECT (entry_active=1):
//    digit, count<DIGITS -> buffer=(buffer<<4)|digit, count+1.
//    digit, count==DIGITS -> ignored, entry_error pulse.
//    backspace -> buffer>>4, count-1; count reaching 0 -> IDLE.
//    clear -> buffer=0, count=0, IDLE, no error.
//    enter, count==DIGITS -> SEND; enter, count<DIGITS -> entry_error pulse, stay.
//    invalid code -> entry_error pulse, stay.
//  - Timer: cleared on entry to COLLECT and on every key_valid there; increments otherwise. On reaching
//    TIMEOUT_CYC -> IDLE, buffer/count cleared, entry_error pulse.
//  - SEND: pin_valid=1, pin_data stable; all keys ignored (no error). pin_valid&pin_ready -> IDLE next
//    cycle, pin_valid=0, pin_data/count cleared. No timeout in SEND.
//  - LOCKED: keys ignored, outputs zero; lock_in=0 -> IDLE next cycle.
//  - pin_valid must never drop without pin_ready, except on lock_in or rst.
// TESTING
//  1. keys 1,2,3,4,E, pin_ready=1 -> pin_valid high 1 cycle after E, pin_data=16'h1234, then IDLE, count=0.
//  2. same PIN, pin_ready=0 for 10 cycles, extra keys 7,E -> pin_valid/pin_data=16'h1234 held; released on ready.
//  3. keys 1,2,B,5,6,7,E -> pin_data=16'h1567; digit_count trace 1,2,1,2,3,4.
//  4. keys 9,8,7,E -> entry_error pulse, no pin_valid; then 6,5 -> count=4, 5 rejected with error, data=16'h9876.
//  5. TIMEOUT_CYC=16: keys 3,4 then idle 16 cycles -> entry_error pulse, IDLE, count=0; key C -> error in IDLE.
//  6. lock_in=1 during COLLECT and during SEND -> LOCKED, pin_valid=0, keys ignored; lock_in=0 then 1,2,3,4,E
//     -> 16'h1234 delivered; rst asserted mid-entry -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/keypad_pin_entry_if.sv
// Keypad-to-gate PIN bus: keystroke input, lockout, and the PIN valid/ready handshake.
interface keypad_pin_entry_if #(
  parameter int DIGITS = 4
);
  logic                  key_valid;
  logic [3:0]            key_code;
  logic                  lock_in;
  logic                  pin_ready;
  logic                  pin_valid;
  logic [4*DIGITS-1:0]   pin_data;
  logic                  entry_active;
  logic [2:0]            digit_count;
  logic                  entry_error;

  modport master (
    output key_valid, key_code, lock_in, pin_ready,
    input  pin_valid, pin_data, entry_active, digit_count, entry_error
  );

  modport slave (
    input  key_valid, key_code, lock_in, pin_ready,
    output pin_valid, pin_data, entry_active, digit_count, entry_error
  );
endinterface

// File: rtl/keypad_pin_entry.sv
// Assembles keypad digits into a BCD PIN and offers it to the gate controller over valid/ready.
// Entry is frozen by lock_in and abandoned after TIMEOUT_CYC idle cycles.
module keypad_pin_entry #(
  parameter int DIGITS      = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst,
  keypad_pin_entry_if.slave  bus
);
  localparam int DW = 4*DIGITS;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0]    FULL = 3'(DIGITS);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SEND, S_LOCKED} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   buf_q, buf_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            err_q, err_d;
  logic            valid_q, active_q;

  logic is_digit, is_clear, is_bs, is_enter, is_cmd;
  assign is_digit = (bus.key_code <= 4'd9);
  assign is_clear = (bus.key_code == 4'hA);
  assign is_bs    = (bus.key_code == 4'hB);
  assign is_enter = (bus.key_code == 4'hE);
  assign is_cmd   = is_clear | is_bs | is_enter;

  // Timer defaults to zero so it restarts on every entry into COLLECT.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    tmr_d   = '0;
    err_d   = 1'b0;
    if (bus.lock_in) begin
      state_d = S_LOCKED;
      buf_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.key_valid) begin
            if (is_digit) begin
              buf_d   = DW'(bus.key_code);
              cnt_d   = 3'd1;
              state_d = S_COLLECT;
            end else if (!is_cmd) begin
              err_d = 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (bus.key_valid) begin
            if (is_digit) begin
              if (cnt_q < FULL) begin
                buf_d = (buf_q << 4) | DW'(bus.key_code);
                cnt_d = cnt_q + 3'd1;
              end else begin
                err_d = 1'b1;
              end
            end else if (is_bs) begin
              buf_d = buf_q >> 4;
              cnt_d = cnt_q - 3'd1;
              if (cnt_q == 3'd1) state_d = S_IDLE;
            end else if (is_clear) begin
              buf_d   = '0;
              cnt_d   = '0;
              state_d = S_IDLE;
            end else if (is_enter) begin
              if (cnt_q == FULL) state_d = S_SEND;
              else               err_d   = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (tmr_q == TMAX) begin
            buf_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        S_SEND: begin
          // PIN held untouched until the consumer takes it.
          if (bus.pin_ready) begin
            buf_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      err_q    <= err_d;
      valid_q  <= (state_d == S_SEND);
      active_q <= (state_d == S_COLLECT);
    end
  end

  assign bus.pin_valid    = valid_q;
  assign bus.pin_data     = buf_q;
  assign bus.entry_active = active_q;
  assign bus.digit_count  = cnt_q;
  assign bus.entry_error  = err_q;

  // Handshake must not be withdrawn by the producer.
  a_valid_hold: assert property (@(posedge clk) disable iff (rst)
    valid_q && !bus.pin_ready && !bus.lock_in |=> valid_q);
  a_count_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= FULL);
endmodule
